// File: rtl/isp_yuv2rgb.sv
// YUV to RGB converter (BT.601 full-range or BT.709 limited-range per pixel); ISP_YUV2RGB_422_EN selects 4:2:2 input.
// Latency: 6 clocks (7 with ISP_YUV2RGB_422_EN); one pixel per clock.
// Backpressure: none, fully pipelined; sync signals follow through a matching delay line.
module isp_yuv2rgb #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [1:0]      in_conv_standard,
    input  logic [7:0]      in_y,
    input  logic [7:0]      in_u,
    input  logic [7:0]      in_v,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_r,
    output logic [BITS-1:0] out_g,
    output logic [BITS-1:0] out_b
);

`ifdef ISP_YUV2RGB_422_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    // Frame geometry is informational only.
    localparam int unused_frame_area = WIDTH * HEIGHT;

    // 20-bit signed intermediates cover the worst case (~+/-140k) with margin.
    localparam int SW = 20;
    localparam logic signed [SW-1:0] K_RND   = 20'sd128;
    localparam logic signed [SW-1:0] K_OFS   = 20'sd128;
    localparam logic signed [SW-1:0] K_Y16   = 20'sd16;
    localparam logic signed [SW-1:0] K709_Y  = 20'sd298;
    localparam logic signed [SW-1:0] K601_RV = 20'sd359;
    localparam logic signed [SW-1:0] K601_GU = 20'sd88;
    localparam logic signed [SW-1:0] K601_GV = 20'sd183;
    localparam logic signed [SW-1:0] K601_BU = 20'sd454;
    localparam logic signed [SW-1:0] K709_RV = 20'sd459;
    localparam logic signed [SW-1:0] K709_GU = 20'sd55;
    localparam logic signed [SW-1:0] K709_GV = 20'sd136;
    localparam logic signed [SW-1:0] K709_BU = 20'sd541;

    function automatic logic [7:0] clip8(input logic signed [SW-1:0] x);
        logic [7:0] r;
        if (x[SW-1])
            r = 8'd0;
        else if (|x[SW-2:8])
            r = 8'hff;
        else
            r = x[7:0];
        return r;
    endfunction

    function automatic logic [BITS-1:0] widen(input logic [7:0] x);
        return BITS'(x) << (BITS - 8);
    endfunction

    // Front end: pixel entering the arithmetic pipe with its own chroma pair.
    logic [7:0] f_y, f_u, f_v;
    logic       f_709;

`ifdef ISP_YUV2RGB_422_EN
    logic       ph;
    logic       a_vld, a_ph, a_709;
    logic [7:0] a_y, a_c, u_hold;
    logic       unused_in_v;

    assign unused_in_v = ^in_v;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= 1'b0;
            a_vld  <= 1'b0;
            a_ph   <= 1'b0;
            a_709  <= 1'b0;
            a_y    <= 8'd0;
            a_c    <= 8'd0;
            u_hold <= 8'd0;
        end else begin
            ph    <= in_href ? ~ph : 1'b0;
            a_vld <= in_href;
            a_ph  <= ph;
            a_709 <= (in_conv_standard == 2'b01);
            a_y   <= in_y;
            a_c   <= in_u;
            if (a_vld && !a_ph)
                u_hold <= a_c;
        end
    end

    // Even pixel looks ahead at the live input for its V; a missing partner means V = 128.
    always_comb begin
        f_y   = a_y;
        f_709 = a_709;
        f_u   = a_ph ? u_hold : a_c;
        f_v   = a_ph ? a_c : (in_href ? in_u : 8'd128);
    end
`else
    always_comb begin
        f_y   = in_y;
        f_u   = in_u;
        f_v   = in_v;
        f_709 = (in_conv_standard == 2'b01);
    end
`endif

    logic                  s1_709;
    logic [7:0]            s1_y, s1_u, s1_v;
    logic                  s2_709;
    logic signed [SW-1:0]  s2_y, s2_u, s2_v;
    logic signed [SW-1:0]  s3_y, s3_pr, s3_pg, s3_pb;
    logic signed [SW-1:0]  s4_r, s4_g, s4_b;
    logic [7:0]            s5_r, s5_g, s5_b;
    logic [LAT-1:0]        href_sr, vsync_sr;
    logic signed [SW-1:0]  y_ext;

    assign y_ext = {12'd0, s1_y};

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_709   <= 1'b0;
            s1_y     <= 8'd0;
            s1_u     <= 8'd0;
            s1_v     <= 8'd0;
            s2_709   <= 1'b0;
            s2_y     <= '0;
            s2_u     <= '0;
            s2_v     <= '0;
            s3_y     <= '0;
            s3_pr    <= '0;
            s3_pg    <= '0;
            s3_pb    <= '0;
            s4_r     <= '0;
            s4_g     <= '0;
            s4_b     <= '0;
            s5_r     <= 8'd0;
            s5_g     <= 8'd0;
            s5_b     <= 8'd0;
            href_sr  <= '0;
            vsync_sr <= '0;
            out_r    <= '0;
            out_g    <= '0;
            out_b    <= '0;
        end else begin
            s1_709 <= f_709;
            s1_y   <= f_y;
            s1_u   <= f_u;
            s1_v   <= f_v;

            s2_709 <= s1_709;
            s2_y   <= s1_709 ? (y_ext - K_Y16) * K709_Y : y_ext <<< 8;
            s2_u   <= {12'd0, s1_u} - K_OFS;
            s2_v   <= {12'd0, s1_v} - K_OFS;

            s3_y   <= s2_y;
            s3_pr  <= s2_709 ? s2_v * K709_RV : s2_v * K601_RV;
            s3_pg  <= s2_709 ? s2_u * K709_GU + s2_v * K709_GV
                             : s2_u * K601_GU + s2_v * K601_GV;
            s3_pb  <= s2_709 ? s2_u * K709_BU : s2_u * K601_BU;

            // Round, then arithmetic shift floors toward minus infinity.
            s4_r   <= (s3_y + s3_pr + K_RND) >>> 8;
            s4_g   <= (s3_y - s3_pg + K_RND) >>> 8;
            s4_b   <= (s3_y + s3_pb + K_RND) >>> 8;

            s5_r   <= clip8(s4_r);
            s5_g   <= clip8(s4_g);
            s5_b   <= clip8(s4_b);

            href_sr  <= {href_sr[LAT-2:0], in_href};
            vsync_sr <= {vsync_sr[LAT-2:0], in_vsync};

            out_r  <= href_sr[LAT-2] ? widen(s5_r) : '0;
            out_g  <= href_sr[LAT-2] ? widen(s5_g) : '0;
            out_b  <= href_sr[LAT-2] ? widen(s5_b) : '0;
        end
    end

    assign out_href  = href_sr[LAT-1];
    assign out_vsync = vsync_sr[LAT-1];

endmodule

// File: tb/tb_isp_yuv2rgb.sv
// Bench for isp_yuv2rgb: 8-bit and 10-bit instances share stimulus; scoreboard of expected pixels.
module tb_isp_yuv2rgb;

`ifdef ISP_YUV2RGB_422_EN
    localparam int L = 7;
`else
    localparam int L = 6;
`endif

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_href = 1'b0;
    logic       in_vsync = 1'b0;
    logic [1:0] in_conv_standard = 2'b00;
    logic [7:0] in_y = 8'd0, in_u = 8'd0, in_v = 8'd0;
    logic       out_href, out_vsync;
    logic [7:0] out_r, out_g, out_b;
    logic       w_href, w_vsync;
    logic [9:0] w_r, w_g, w_b;

    isp_yuv2rgb #(.BITS(8)) dut (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
        .in_conv_standard(in_conv_standard), .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .out_href(out_href), .out_vsync(out_vsync), .out_r(out_r), .out_g(out_g), .out_b(out_b)
    );

    isp_yuv2rgb #(.BITS(10)) dut10 (
        .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
        .in_conv_standard(in_conv_standard), .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .out_href(w_href), .out_vsync(w_vsync), .out_r(w_r), .out_g(w_g), .out_b(w_b)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t sbq[$];
    logic href_hist[int];
    logic vs_hist[int];
    int   errors = 0;
    int   checks = 0;

    int         p_y, p_u, p_due;
    logic [1:0] p_st;
    logic       p_have = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clip(input int x);
        int s;
        s = (x + 128) >>> 8;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic exp_t model(input int y, input int u, input int v,
                                   input logic [1:0] st, input int due);
        exp_t e;
        int   up, vp, yy;
        up = u - 128;
        vp = v - 128;
        if (st == 2'b01) begin
            yy  = 298 * (y - 16);
            e.r = clip(yy + 459 * vp);
            e.g = clip(yy - 55 * up - 136 * vp);
            e.b = clip(yy + 541 * up);
        end else begin
            yy  = 256 * y;
            e.r = clip(yy + 359 * vp);
            e.g = clip(yy - 88 * up - 183 * vp);
            e.b = clip(yy + 454 * up);
        end
        e.due = due;
        return e;
    endfunction

    task automatic pix(input logic h, input logic vs, input logic [1:0] st,
                       input int y, input int u, input int v);
        @(posedge pclk);
        #2;
        in_href          = h;
        in_vsync         = vs;
        in_conv_standard = st;
        in_y             = 8'(y);
        in_u             = 8'(u);
        in_v             = 8'(v);
        href_hist[cyc]   = h;
        vs_hist[cyc]     = vs;
`ifdef ISP_YUV2RGB_422_EN
        if (h) begin
            if (!p_have) begin
                p_y = y; p_u = u; p_st = st; p_due = cyc + L; p_have = 1'b1;
            end else begin
                sbq.push_back(model(p_y, p_u, u, p_st, p_due));
                sbq.push_back(model(y, p_u, u, st, cyc + L));
                p_have = 1'b0;
            end
        end else if (p_have) begin
            sbq.push_back(model(p_y, p_u, 128, p_st, p_due));
            p_have = 1'b0;
        end
`else
        if (h) sbq.push_back(model(y, u, v, st, cyc + L));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            pix(1'b0, 1'b0, 2'(i), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic rnd_line(input int n, input logic [1:0] st, input logic any_std);
        for (int i = 0; i < n; i++)
            pix(1'b1, 1'b0, any_std ? 2'($urandom_range(0, 3)) : st,
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    // Pipeline contents are lost on reset, so nothing in flight is expected afterwards.
    task automatic reset_pulse(input int n);
        @(posedge pclk);
        #2;
        rst_n    = 1'b0;
        in_href  = 1'b0;
        in_vsync = 1'b0;
        sbq.delete();
        href_hist.delete();
        vs_hist.delete();
        p_have = 1'b0;
        repeat (n) @(posedge pclk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge pclk) begin
        logic eh, ev;
        exp_t e;
        eh = href_hist.exists(cyc - L) ? href_hist[cyc - L] : 1'b0;
        ev = vs_hist.exists(cyc - L) ? vs_hist[cyc - L] : 1'b0;
        check("out_href", int'(out_href), int'(eh));
        check("out_vsync", int'(out_vsync), int'(ev));
        check("out_href_10b", int'(w_href), int'(eh));
        check("out_vsync_10b", int'(w_vsync), int'(ev));
        if (out_href) begin
            if (sbq.size() == 0) begin
                check("unexpected_pixel", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                check("latency", cyc, e.due);
                check("r", int'(out_r), e.r);
                check("g", int'(out_g), e.g);
                check("b", int'(out_b), e.b);
                check("r_10b", int'(w_r), e.r * 4);
                check("g_10b", int'(w_g), e.g * 4);
                check("b_10b", int'(w_b), e.b * 4);
            end
        end else begin
            check("idle_rgb", int'({out_r, out_g, out_b}), 0);
            check("idle_rgb_10b", int'({w_r, w_g, w_b}), 0);
        end
    end

    initial begin
        repeat (3) @(posedge pclk);
        #2;
        rst_n = 1'b1;
        idle(2);
        pix(1'b0, 1'b1, 2'b00, 0, 0, 0);
        idle(1);

        // BT.601 mid-grey and both clip ends, then random pixels with non-709 codes.
        pix(1'b1, 1'b0, 2'b00, 128, 128, 128);
        pix(1'b1, 1'b0, 2'b00, 255, 128, 255);
        pix(1'b1, 1'b0, 2'b00, 0, 128, 0);
        rnd_line(3, 2'b10, 1'b0);
        rnd_line(3, 2'b11, 1'b0);
        idle(3);

        // BT.709 black and white points.
        pix(1'b1, 1'b0, 2'b01, 16, 128, 128);
        pix(1'b1, 1'b0, 2'b01, 235, 128, 128);
        rnd_line(6, 2'b01, 1'b0);
        idle(2);

        // Standard toggles every pixel, with a data-carrying gap mid-line.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                pix(1'b0, 1'b0, 2'b01, 99, 7, 200);
                pix(1'b0, 1'b0, 2'b00, 3, 250, 1);
            end
            pix(1'b1, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b00, 235, 128, 128);
        end
        idle(2);

        // Alternating chroma lines, even and odd length.
        for (int i = 0; i < 6; i++)
            pix(1'b1, 1'b0, 2'b00, 128, (i % 2 == 0) ? 255 : 0, $urandom_range(0, 255));
        idle(2);
        for (int i = 0; i < 5; i++)
            pix(1'b1, 1'b0, 2'b00, 128, (i % 2 == 0) ? 255 : 0, $urandom_range(0, 255));
        idle(2);

        rnd_line(20, 2'b00, 1'b1);
        idle(1);

        // Reset mid-line, then a fresh line must come out at latency L.
        rnd_line(4, 2'b00, 1'b1);
        reset_pulse(2);
        idle(2);
        rnd_line(5, 2'b00, 1'b1);
        idle(L + 4);

        check("drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
